bench_scan_sequencer: RTL and testbench

//   Autonomous scan controller for the 8-way benchmark output mux. On start it walks the
//   3-bit design-select code through every enabled slot in ascending order. Each slot gets
//   one settle cycle plus a programmable dwell. At the end of each dwell it folds the

---
 rtl/bench_ctrl_pkg.sv | 16 +
 rtl/bench_scan_sequencer_if.sv | 25 ++
 rtl/next_slot_finder.sv | 33 +++
 rtl/bench_scan_sequencer.sv | 114 +++++++++++
 tb/tb_bench_scan_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bench_ctrl_pkg.sv
// Shared definitions for the benchmark scan controller and the output-mux wrapper.
package bench_ctrl_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SEL_W     = 3;
  localparam int DATA_W    = 8;
  localparam int DWELL_W   = 4;

  localparam logic [DATA_W-1:0] SIG_INIT = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/bench_scan_sequencer_if.sv
// Control/status bundle between the scan sequencer and whoever drives it.
interface bench_scan_sequencer_if
  import bench_ctrl_pkg::*;
  ();
  logic                 start;
  logic                 abort;
  logic [NUM_SLOTS-1:0] slot_mask;
  logic [DWELL_W-1:0]   dwell;
  logic [DATA_W-1:0]    data_in;
  logic [SEL_W-1:0]     sel;
  logic                 busy;
  logic                 capture;
  logic                 done;
  logic [DATA_W-1:0]    signature;

  modport master (
    output start, abort, slot_mask, dwell, data_in,
    input  sel, busy, capture, done, signature
  );

  modport slave (
    input  start, abort, slot_mask, dwell, data_in,
    output sel, busy, capture, done, signature
  );
endinterface

// File: rtl/next_slot_finder.sv
// Lowest set mask bit strictly above sel, or the lowest set bit overall when from_start.
module next_slot_finder #(
  parameter int NUM_SLOTS = 8,
  parameter int SEL_W     = 3
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 from_start,
  output logic [SEL_W-1:0]     nxt,
  output logic                 found
);
  logic [NUM_SLOTS-1:0] cand;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_cand
    if (i == 0) begin : g_lo
      assign cand[i] = mask[i] & from_start;
    end else begin : g_hi
      assign cand[i] = mask[i] & (from_start | (sel < SEL_W'(i)));
    end
  end

  // Descending walk so the lowest candidate is the final assignment.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bench_scan_sequencer.sv
// Walks the mux select over enabled slots, dwelling on each and folding the
// selected output into a rotate-XOR signature.
module bench_scan_sequencer
  import bench_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  bench_scan_sequencer_if.slave  bus
);
  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]    sig_q, sig_d;
  logic                 capture;
  logic                 idle;
  logic [NUM_SLOTS-1:0] find_mask;
  logic [SEL_W-1:0]     nxt;
  logic                 found;

  // In IDLE the finder looks at the live mask for the first slot; afterwards
  // it steps through the latched copy.
  assign idle      = (state_q == ST_IDLE);
  assign find_mask = idle ? bus.slot_mask : mask_q;

  next_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SEL_W     (SEL_W)
  ) u_find (
    .mask       (find_mask),
    .sel        (sel_q),
    .from_start (idle),
    .nxt        (nxt),
    .found      (found)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sig_d   = sig_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          sig_d = SIG_INIT;
          if (found) begin
            mask_d  = bus.slot_mask;
            dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
            sel_d   = nxt;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = dwell_q - 1'b1;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (bus.abort) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          sig_d   = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ bus.data_in;
          if (found) begin
            sel_d   = nxt;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      sig_q   <= SIG_INIT;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      sig_q   <= sig_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_DWELL);
  assign bus.capture   = capture;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.signature = sig_q;
endmodule

// File: tb/tb_bench_scan_sequencer.sv
// Randomised scoreboard bench for bench_scan_sequencer against a slot-list reference model.
module tb_bench_scan_sequencer;
  import bench_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bench_scan_sequencer_if bus ();

  bench_scan_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-slot design outputs; the mux model answers whatever sel points at.
  logic [7:0] lut [8];
  always_comb bus.data_in = lut[bus.sel];

  typedef struct { int cyc; logic [2:0] sel; } cap_t;
  typedef struct { int cyc; logic [7:0] sig; } done_t;
  cap_t  cq [$];
  done_t dq [$];
  int         bt0 = 0;
  int         bend = 0;
  logic [7:0] cur_mask = '0;
  logic [7:0] exp_sig = '0;
  int         nchk = 0;
  int         nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", 32'(bus.busy), 32'(cyc >= bt0 && cyc < bend));
      if (bus.busy) chk("sel_in_mask", 32'(cur_mask[bus.sel]), 32'd1);
      if (bus.capture) begin
        cap_t e;
        if (cq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_capture: capture high at cycle %0d, none expected", cyc);
        end else begin
          e = cq.pop_front();
          chk("capture_cycle", 32'(cyc), 32'(e.cyc));
          chk("capture_sel", 32'(bus.sel), 32'(e.sel));
        end
      end
      if (bus.done) begin
        done_t e;
        if (dq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_done: done high at cycle %0d, none expected", cyc);
        end else begin
          e = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_sig", 32'(bus.signature), 32'(e.sig));
        end
      end
    end
  end

  // Issue a start and load the scoreboard from the slot list the mask describes.
  task automatic kick(input logic [7:0] m, input logic [3:0] d, input int abort_slot,
                      output int t0, output int deff);
    logic [7:0] s;
    int         j;
    int         n;
    cap_t       ce;
    done_t      de;
    @(posedge clk); #1;
    bus.slot_mask = m; bus.dwell = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.slot_mask = 8'($urandom);
    bus.dwell = 4'($urandom);
    t0 = cyc;
    deff = (d == 0) ? 1 : int'(d);
    s = SIG_INIT;
    j = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k] && j != abort_slot) begin
        s = ((s << 1) | (s >> 7)) ^ lut[k];
        ce.cyc = t0 + (j + 1) * (1 + deff) - 1;
        ce.sel = 3'(k);
        cq.push_back(ce);
        j++;
      end else if (m[k]) begin
        break;
      end
    end
    n = $countones(m);
    cur_mask = m;
    bt0 = t0;
    exp_sig = s;
    if (abort_slot >= 0) begin
      bend = t0 + abort_slot * (1 + deff) + 2;
    end else begin
      bend = t0 + n * (1 + deff);
      de.cyc = bend;
      de.sig = s;
      dq.push_back(de);
    end
  endtask

  task automatic run(input logic [7:0] m, input logic [3:0] d, input int abort_slot, input bit poke);
    int t0, deff, c;
    kick(m, d, abort_slot, t0, deff);
    if (abort_slot >= 0) begin
      c = bend - 1;
      while (cyc < c) begin
        @(posedge clk); #1;
        bus.start = poke && (cyc == t0 + 2);
      end
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_sel", 32'(bus.sel), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sig", 32'(bus.signature), 32'(exp_sig));
      repeat (3) @(posedge clk);
      #1;
    end else begin
      while (cyc <= bend + 1) begin
        @(posedge clk); #1;
        bus.start = poke && (cyc == t0 + 2) && (bend > t0 + 3);
      end
      bus.start = 1'b0;
      chk("final_sig", 32'(bus.signature), 32'(exp_sig));
    end
    chk("capq_empty", 32'(cq.size()), 32'd0);
    chk("doneq_empty", 32'(dq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, deff;
    logic [7:0] m;
    bus.start = 1'b0; bus.abort = 1'b0; bus.slot_mask = '0; bus.dwell = '0;
    for (int i = 0; i < 8; i++) lut[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_capture", 32'(bus.capture), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sig", 32'(bus.signature), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) lut[i] = 8'hA5;
    run(8'h01, 4'd0, -1, 1'b0);
    chk("t1_sig", 32'(bus.signature), 32'hA5);
    run(8'h03, 4'd1, -1, 1'b0);
    chk("t2_sig", 32'(bus.signature), 32'hEE);

    for (int i = 0; i < 8; i++) lut[i] = 8'(i);
    run(8'hFF, 4'd2, -1, 1'b1);

    for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
    run(8'h90, 4'd3, -1, 1'b0);

    for (int i = 0; i < 8; i++) lut[i] = 8'($urandom);
    run(8'hFF, 4'($urandom_range(1, 4)), 3, 1'b1);

    // Asynchronous reset in the middle of a scan.
    kick(8'hFF, 4'd5, -1, t0, deff);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_capture", 32'(bus.capture), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_sig", 32'(bus.signature), 32'd0);
    cq.delete(); dq.delete(); bend = 0; exp_sig = '0;
    #1 reset_n = 1'b1;

    run(8'h00, 4'd7, -1, 1'b0);
    chk("t6_sig", 32'(bus.signature), 32'd0);

    // start+abort together in IDLE must do nothing.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.slot_mask = 8'hFF; bus.dwell = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_abort_busy", 32'(bus.busy), 32'd0);
    chk("idle_abort_sig", 32'(bus.signature), 32'(exp_sig));

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 8; k++) lut[k] = 8'($urandom);
      m = 8'($urandom);
      if (i % 4 == 0) m = 8'h00;
      run(m, 4'($urandom), -1, (i % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
